// File: rtl/fei4_record_decoder.sv
// ============================================================================
// fei4_record_decoder
//
// Purpose:
//   Sits behind the FE-I4 receiver FIFO (first-word-fall-through). Pops one
//   24-bit decoded record per cycle whenever the output register can take it,
//   classifies the record by its header byte, tracks trigger/event boundaries
//   from data headers, and forwards every record unchanged as a 32-bit word
//   tagged with the channel ID. Keeps saturating error/status counters.
//
// Parameters:
//   CHANNEL_ID      7-bit channel tag placed in OUT_DATA[30:24]
//   DH_PER_TRIGGER  data headers per trigger (1..256), defines event boundary
//
// Ports:
//   BUS_CLK         in   1   single clock, rising edge
//   RESET           in   1   synchronous active-high reset
//   FIFO_DATA       in   24  record at FIFO head, valid while !FIFO_EMPTY
//   FIFO_EMPTY      in   1   receiver FIFO empty
//   FIFO_READ       out  1   pop strobe (combinational)
//   OUT_DATA        out  32  {1'b0, CHANNEL_ID, record}
//   OUT_VALID       out  1   OUT_DATA valid
//   OUT_READY       in   1   consumer accepts when OUT_VALID & OUT_READY
//   EVENT_CNT       out  16  completed triggers (wraps)
//   ORPHAN_ERR_CNT  out  8   data records seen outside an event (saturating)
//   BCID_ERR_CNT    out  8   BCID discontinuities inside a trigger (saturating)
//   SR_CNT          out  8   service records seen (saturating)
//   IN_EVENT        out  1   high while inside a trigger
//
// Configuration:
//   FEI4_BCID_CHECK_EN  when defined, consecutive data headers of one trigger
//                       must carry incrementing BCIDs (mod 256); each break
//                       bumps BCID_ERR_CNT. When undefined the check and its
//                       BCID history register are absent and BCID_ERR_CNT
//                       reads 8'h00.
// ============================================================================
module fei4_record_decoder #(
    parameter int CHANNEL_ID     = 0,
    parameter int DH_PER_TRIGGER = 16
) (
    input  logic        BUS_CLK,
    input  logic        RESET,
    input  logic [23:0] FIFO_DATA,
    input  logic        FIFO_EMPTY,
    output logic        FIFO_READ,
    output logic [31:0] OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [15:0] EVENT_CNT,
    output logic [7:0]  ORPHAN_ERR_CNT,
    output logic [7:0]  BCID_ERR_CNT,
    output logic [7:0]  SR_CNT,
    output logic        IN_EVENT
);

    typedef enum logic {
        WAIT_DH = 1'b0,
        IN_EVT  = 1'b1
    } state_t;

    localparam logic [6:0] CH_TAG   = 7'(CHANNEL_ID);
    // Index of the last data header of a trigger; 0 means a single header
    // closes the event on its own.
    localparam logic [7:0] LAST_IDX = 8'(DH_PER_TRIGGER - 1);

    state_t     state_q, state_d;
    logic [7:0] dh_idx_q, dh_idx_d;
    logic       pop;
    logic       is_dh, is_sr, is_dr;
    logic       evt_done;
    logic       orphan_hit;
    logic       in_event;

    // Pop only when the output register is free or being drained this cycle,
    // so a word is never overwritten before it has been accepted.
    assign pop       = !RESET && !FIFO_EMPTY && (!OUT_VALID || OUT_READY);
    assign FIFO_READ = pop;

    assign is_dh = (FIFO_DATA[23:16] == 8'hE9);
    assign is_sr = (FIFO_DATA[23:16] == 8'hEF);
    assign is_dr = !(is_dh || is_sr ||
                     (FIFO_DATA[23:16] == 8'hEA) ||
                     (FIFO_DATA[23:16] == 8'hEC));

    // Output register: loads on pop, otherwise clears once accepted.
    always_ff @(posedge BUS_CLK) begin
        if (RESET) begin
            OUT_DATA  <= 32'h0;
            OUT_VALID <= 1'b0;
        end else if (pop) begin
            OUT_DATA  <= {1'b0, CH_TAG, FIFO_DATA};
            OUT_VALID <= 1'b1;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

    // FSM state register together with the header index it steps.
    always_ff @(posedge BUS_CLK) begin
        if (RESET) begin
            state_q  <= WAIT_DH;
            dh_idx_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            dh_idx_q <= dh_idx_d;
        end
    end

    // Next-state logic: the FSM only moves on a pop, and only data headers
    // move it; a trigger closes on its DH_PER_TRIGGER-th header.
    always_comb begin
        state_d    = state_q;
        dh_idx_d   = dh_idx_q;
        evt_done   = 1'b0;
        orphan_hit = 1'b0;
        if (pop) begin
            case (state_q)
                WAIT_DH: begin
                    if (is_dh) begin
                        if (LAST_IDX == 8'd0) begin
                            evt_done = 1'b1;
                            dh_idx_d = 8'd0;
                        end else begin
                            state_d  = IN_EVT;
                            dh_idx_d = 8'd1;
                        end
                    end else if (is_dr) begin
                        orphan_hit = 1'b1;
                    end
                end
                IN_EVT: begin
                    if (is_dh) begin
                        if (dh_idx_q == LAST_IDX) begin
                            evt_done = 1'b1;
                            dh_idx_d = 8'd0;
                            state_d  = WAIT_DH;
                        end else begin
                            dh_idx_d = dh_idx_q + 8'd1;
                        end
                    end
                end
                default: state_d = WAIT_DH;
            endcase
        end
    end

    // Output decode: event flag comes straight from the state register.
    always_comb begin
        in_event = (state_q == IN_EVT);
    end

    assign IN_EVENT = in_event;

    // Status counters: one record per pop, so at most one increment each.
    always_ff @(posedge BUS_CLK) begin
        if (RESET) begin
            EVENT_CNT      <= 16'h0;
            ORPHAN_ERR_CNT <= 8'h0;
            SR_CNT         <= 8'h0;
        end else begin
            if (evt_done)
                EVENT_CNT <= EVENT_CNT + 16'd1;
            if (orphan_hit && ORPHAN_ERR_CNT != 8'hFF)
                ORPHAN_ERR_CNT <= ORPHAN_ERR_CNT + 8'd1;
            if (pop && is_sr && SR_CNT != 8'hFF)
                SR_CNT <= SR_CNT + 8'd1;
        end
    end

`ifdef FEI4_BCID_CHECK_EN
    logic [7:0] last_bcid;
    logic       bcid_bad;

    // Only headers after the first one in a trigger are checked; the first
    // header just seeds the expected sequence.
    assign bcid_bad = pop && is_dh && (state_q == IN_EVT) &&
                      (FIFO_DATA[7:0] != last_bcid + 8'd1);

    always_ff @(posedge BUS_CLK) begin
        if (RESET) begin
            last_bcid    <= 8'h0;
            BCID_ERR_CNT <= 8'h0;
        end else begin
            if (pop && is_dh)
                last_bcid <= FIFO_DATA[7:0];
            if (bcid_bad && BCID_ERR_CNT != 8'hFF)
                BCID_ERR_CNT <= BCID_ERR_CNT + 8'd1;
        end
    end
`else
    assign BCID_ERR_CNT = 8'h00;
`endif

endmodule
